cheriot_dv_mem_cmd_tracker: RTL and testbench

Parametrised multi-channel memory-command tracker for the CHERIoT DV testbench. It captures every granted request on each of `NumChan` memory ports into a per-channel in-order queue, pairs it with its response, and tags it with decoded DV flags. It then retires one completed `mem_cmd_t` per cycle through a round-robin arbiter to scoreboards and coverage collectors. It sits beside the memory models in the testbench and is never synthesised into the core.

---
 rtl/cheriot_dv_pkg.sv | 26 ++
 rtl/cheriot_dv_cmd_fifo.sv | 86 ++++++++
 rtl/cheriot_dv_mem_cmd_tracker.sv | 149 ++++++++++++++
 tb/tb_cheriot_dv_mem_cmd_tracker.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cheriot_dv_pkg.sv
// rtl/cheriot_dv_pkg.sv - shared types and constants for the DV memory-command tracker
package cheriot_dv_pkg;

   localparam logic [31:0] DefDramStart  = 32'h8000_0000;
   localparam logic [31:0] DefDramSize   = 32'h0100_0000;
   localparam logic [31:0] DefTsMapStart = 32'h8300_0000;
   localparam logic [32:0] TsMapSize     = 33'h0_0000_1000;

   localparam int FlagCapMisal   = 0;
   localparam int FlagOutDram    = 1;
   localparam int FlagTsMap      = 2;
   localparam int FlagNoBe       = 3;
   localparam int FlagCapPartial = 4;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [29:0] addr32;
      logic        is_cap;
      logic [64:0] wdata;
      logic [64:0] rdata;
      logic        err;
      logic [7:0]  flag;
   } mem_cmd_t;

endpackage

// File: rtl/cheriot_dv_cmd_fifo.sv
// rtl/cheriot_dv_cmd_fifo.sv - per-channel in-order command queue with response matching
module cheriot_dv_cmd_fifo
   import cheriot_dv_pkg::*;
#(
   parameter int Depth = 4,
   localparam int PtrW = $clog2(Depth),
   localparam int CntW = $clog2(Depth + 1)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push,
   input  mem_cmd_t        i_push_cmd,
   input  logic            i_rvalid,
   input  logic [64:0]     i_rdata,
   input  logic            i_err,
   input  logic            i_pop,
   output logic            o_head_valid,
   output mem_cmd_t        o_head,
   output logic [CntW-1:0] o_count,
   output logic            o_overflow,
   output logic            o_spurious
);

   mem_cmd_t        r_mem [Depth];
   logic [PtrW-1:0] r_rd_ptr;
   logic [PtrW-1:0] r_wr_ptr;
   logic [CntW-1:0] r_count;
   logic [CntW-1:0] r_n_done;

   logic            w_full;
   logic            w_pending;
   logic            w_resp_ok;
   logic            w_resp_head;
   logic            w_pop;
   logic            w_push_ok;
   logic [PtrW-1:0] w_done_ptr;
   logic [64:0]     w_resp_rdata;

   // Entries [rd_ptr, rd_ptr+n_done) are done; the rest are awaiting responses.
   assign w_full       = (r_count == CntW'(Depth));
   assign w_pending    = (r_n_done < r_count);
   assign w_resp_ok    = i_rvalid && w_pending;
   assign w_resp_head  = w_resp_ok && (r_n_done == '0);
   assign w_done_ptr   = r_rd_ptr + r_n_done[PtrW-1:0];
   assign w_resp_rdata = r_mem[w_done_ptr].we ? 65'd0 : i_rdata;

   // A response to the head retires it in the same cycle instead of waiting for done to register.
   assign o_head_valid = (r_n_done != '0) || w_resp_head;
   always_comb begin
      o_head = r_mem[r_rd_ptr];
      if (w_resp_head) begin
         o_head.rdata = w_resp_rdata;
         o_head.err   = i_err;
      end
   end

   assign w_pop      = i_pop && o_head_valid;
   assign w_push_ok  = i_push && (!w_full || w_pop);
   assign o_overflow = i_push && w_full && !w_pop;
   assign o_spurious = i_rvalid && !w_resp_ok;
   assign o_count    = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_n_done <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count  <= r_count + CntW'(w_push_ok) - CntW'(w_pop);
         r_n_done <= r_n_done + CntW'(w_resp_ok) - CntW'(w_pop);
      end
   end

   // Push is written last so a push into the slot being popped takes precedence.
   always_ff @(posedge i_clk) begin
      if (w_resp_ok) begin
         r_mem[w_done_ptr].rdata <= w_resp_rdata;
         r_mem[w_done_ptr].err   <= i_err;
      end
      if (w_push_ok) r_mem[r_wr_ptr] <= i_push_cmd;
   end

endmodule

// File: rtl/cheriot_dv_mem_cmd_tracker.sv
// rtl/cheriot_dv_mem_cmd_tracker.sv - multi-channel memory-command tracker with round-robin retirement
module cheriot_dv_mem_cmd_tracker
   import cheriot_dv_pkg::*;
#(
   parameter int          NumChan    = 2,
   parameter int          Depth      = 4,
   parameter logic [31:0] DramStart  = DefDramStart,
   parameter logic [31:0] DramSize   = DefDramSize,
   parameter logic [31:0] TsMapStart = DefTsMapStart,
   localparam int ChanW = (NumChan > 1) ? $clog2(NumChan) : 1,
   localparam int OutW  = $clog2(NumChan * Depth + 1),
   localparam int CntW  = $clog2(Depth + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [NumChan-1:0]    req_i,
   input  logic [NumChan-1:0]    gnt_i,
   input  logic [NumChan-1:0]    we_i,
   input  logic [NumChan*4-1:0]  be_i,
   input  logic [NumChan-1:0]    is_cap_i,
   input  logic [NumChan*30-1:0] addr32_i,
   input  logic [NumChan*65-1:0] wdata_i,
   input  logic [NumChan-1:0]    rvalid_i,
   input  logic [NumChan*65-1:0] rdata_i,
   input  logic [NumChan-1:0]    err_i,
   output logic                  ret_valid_o,
   output logic [ChanW-1:0]      ret_chan_o,
   output mem_cmd_t              ret_cmd_o,
   output logic [OutW-1:0]       outstanding_o,
   output logic [31:0]           retired_cnt_o,
   output logic [NumChan-1:0]    overflow_o,
   output logic [NumChan-1:0]    spurious_o
);

   function automatic logic [7:0] f_flags(input logic we, input logic [3:0] be,
                                          input logic is_cap, input logic [29:0] a);
      logic [32:0] byte_addr;
      logic [7:0]  f;
      byte_addr         = {1'b0, a, 2'b00};
      f                 = '0;
      f[FlagCapMisal]   = is_cap & a[0];
      f[FlagOutDram]    = (byte_addr < {1'b0, DramStart}) ||
                          (byte_addr >= ({1'b0, DramStart} + {1'b0, DramSize}));
      f[FlagTsMap]      = (byte_addr >= {1'b0, TsMapStart}) &&
                          (byte_addr < ({1'b0, TsMapStart} + TsMapSize));
      f[FlagNoBe]       = we && (be == 4'h0);
      f[FlagCapPartial] = is_cap && (be != 4'hF);
      return f;
   endfunction

   mem_cmd_t           w_head [NumChan];
   logic [CntW-1:0]    w_count [NumChan];
   logic [NumChan-1:0] w_head_valid;
   logic [NumChan-1:0] w_pop;
   logic [NumChan-1:0] w_ovf;
   logic [NumChan-1:0] w_spur;
   logic               w_win_valid;
   logic [ChanW-1:0]   w_win;
   logic [ChanW-1:0]   w_ptr_nxt;
   logic [OutW-1:0]    w_outstanding;

   logic [ChanW-1:0]   r_rr_ptr;
   logic               r_ret_valid;
   logic [ChanW-1:0]   r_ret_chan;
   mem_cmd_t           r_ret_cmd;
   logic [31:0]        r_retired_cnt;
   logic [NumChan-1:0] r_overflow;
   logic [NumChan-1:0] r_spurious;

   for (genvar c = 0; c < NumChan; c++) begin : g_chan
      mem_cmd_t w_cmd;
      always_comb begin
         w_cmd        = '0;
         w_cmd.we     = we_i[c];
         w_cmd.be     = be_i[c*4 +: 4];
         w_cmd.addr32 = addr32_i[c*30 +: 30];
         w_cmd.is_cap = is_cap_i[c];
         w_cmd.wdata  = wdata_i[c*65 +: 65];
         w_cmd.flag   = f_flags(we_i[c], be_i[c*4 +: 4], is_cap_i[c], addr32_i[c*30 +: 30]);
      end

      cheriot_dv_cmd_fifo #(.Depth(Depth)) u_fifo (
         .i_clk        (clk_i),
         .i_rst_n      (rst_ni),
         .i_push       (req_i[c] & gnt_i[c]),
         .i_push_cmd   (w_cmd),
         .i_rvalid     (rvalid_i[c]),
         .i_rdata      (rdata_i[c*65 +: 65]),
         .i_err        (err_i[c]),
         .i_pop        (w_pop[c]),
         .o_head_valid (w_head_valid[c]),
         .o_head       (w_head[c]),
         .o_count      (w_count[c]),
         .o_overflow   (w_ovf[c]),
         .o_spurious   (w_spur[c])
      );
   end

   // Scan channels starting at the pointer; first eligible head wins.
   always_comb begin
      w_win_valid = 1'b0;
      w_win       = '0;
      for (int i = 0; i < NumChan; i++) begin
         if (!w_win_valid && w_head_valid[(int'(r_rr_ptr) + i) % NumChan]) begin
            w_win_valid = 1'b1;
            w_win       = ChanW'((int'(r_rr_ptr) + i) % NumChan);
         end
      end
      w_pop = '0;
      if (w_win_valid) w_pop[w_win] = 1'b1;
      w_ptr_nxt = (w_win == ChanW'(NumChan - 1)) ? '0 : w_win + 1'b1;
   end

   always_comb begin
      w_outstanding = '0;
      for (int c = 0; c < NumChan; c++) w_outstanding = w_outstanding + OutW'(w_count[c]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr      <= '0;
         r_ret_valid   <= 1'b0;
         r_ret_chan    <= '0;
         r_ret_cmd     <= '0;
         r_retired_cnt <= '0;
         r_overflow    <= '0;
         r_spurious    <= '0;
      end else begin
         r_ret_valid <= w_win_valid;
         if (w_win_valid) begin
            r_rr_ptr      <= w_ptr_nxt;
            r_ret_chan    <= w_win;
            r_ret_cmd     <= w_head[w_win];
            r_retired_cnt <= r_retired_cnt + 32'd1;
         end
         r_overflow <= r_overflow | w_ovf;
         r_spurious <= r_spurious | w_spur;
      end
   end

   assign ret_valid_o   = r_ret_valid;
   assign ret_chan_o    = r_ret_chan;
   assign ret_cmd_o     = r_ret_cmd;
   assign outstanding_o = w_outstanding;
   assign retired_cnt_o = r_retired_cnt;
   assign overflow_o    = r_overflow;
   assign spurious_o    = r_spurious;

endmodule

// File: tb/tb_cheriot_dv_mem_cmd_tracker.sv
// tb/tb_cheriot_dv_mem_cmd_tracker.sv - directed self-checking bench for the memory-command tracker
module tb_cheriot_dv_mem_cmd_tracker;
   import cheriot_dv_pkg::*;

   localparam int NumChan = 2;
   localparam int Depth   = 4;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NumChan-1:0]    req, gnt, we, is_cap, rvalid, err;
   logic [NumChan*4-1:0]  be;
   logic [NumChan*30-1:0] addr32;
   logic [NumChan*65-1:0] wdata, rdata;
   logic                  ret_valid;
   logic [0:0]            ret_chan;
   mem_cmd_t              ret_cmd;
   logic [3:0]            outstanding;
   logic [31:0]           retired_cnt;
   logic [NumChan-1:0]    overflow, spurious;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   cheriot_dv_mem_cmd_tracker #(.NumChan(NumChan), .Depth(Depth)) dut (
      .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_i(gnt), .we_i(we), .be_i(be),
      .is_cap_i(is_cap), .addr32_i(addr32), .wdata_i(wdata), .rvalid_i(rvalid),
      .rdata_i(rdata), .err_i(err), .ret_valid_o(ret_valid), .ret_chan_o(ret_chan),
      .ret_cmd_o(ret_cmd), .outstanding_o(outstanding), .retired_cnt_o(retired_cnt),
      .overflow_o(overflow), .spurious_o(spurious)
   );

   task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clr();
      req = '0; gnt = '0; we = '0; be = '0; is_cap = '0; addr32 = '0;
      wdata = '0; rvalid = '0; rdata = '0; err = '0;
   endtask

   task automatic acc(input int ch, input logic w, input logic [3:0] b, input logic cap,
                      input logic [29:0] a, input logic [64:0] wd);
      req[ch] = 1'b1; gnt[ch] = 1'b1; we[ch] = w; be[ch*4 +: 4] = b;
      is_cap[ch] = cap; addr32[ch*30 +: 30] = a; wdata[ch*65 +: 65] = wd;
   endtask

   task automatic rsp(input int ch, input logic [64:0] rd, input logic e);
      rvalid[ch] = 1'b1; rdata[ch*65 +: 65] = rd; err[ch] = e;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Two reads on both channels, answered in the same cycle; retirement order follows the pointer.
   task automatic both_chan(input logic first, input string tag);
      clr(); acc(0, 1'b0, 4'hF, 1'b0, 30'h2000_0010, '0); acc(1, 1'b0, 4'hF, 1'b0, 30'h2000_0020, '0);
      tick(); clr();
      check({tag, "_outst"}, outstanding, 4'd2);
      tick();
      rsp(0, 65'h0_0000_1111, 1'b0); rsp(1, 65'h1_0000_2222, 1'b0);
      tick(); clr();
      check({tag, "_v1"}, ret_valid, 1'b1);
      check({tag, "_ch1"}, ret_chan, first);
      check({tag, "_rd1"}, ret_cmd.rdata, first ? 65'h1_0000_2222 : 65'h0_0000_1111);
      tick();
      check({tag, "_v2"}, ret_valid, 1'b1);
      check({tag, "_ch2"}, ret_chan, !first);
      check({tag, "_rd2"}, ret_cmd.rdata, first ? 65'h0_0000_1111 : 65'h1_0000_2222);
      check({tag, "_outst0"}, outstanding, 4'd0);
   endtask

   initial begin
      clr();
      rst_n = 1'b0;
      tick(); tick();
      check("rst_valid", ret_valid, 1'b0);
      check("rst_chan", ret_chan, 1'b0);
      check("rst_cmd", ret_cmd, '0);
      check("rst_outst", outstanding, 4'd0);
      check("rst_cnt", retired_cnt, 32'd0);
      check("rst_ovf", overflow, 2'b00);
      check("rst_spur", spurious, 2'b00);
      rst_n = 1'b1;
      tick();

      both_chan(1'b0, "rr_a");
      check("rr_a_cnt", retired_cnt, 32'd2);

      // Single ch0 read: grant at t, response at t+2, retire visible at t+3.
      acc(0, 1'b0, 4'hF, 1'b0, 30'h2000_0000, '0);
      tick(); clr();
      check("rd_outst", outstanding, 4'd1);
      check("rd_nv0", ret_valid, 1'b0);
      tick();
      check("rd_nv1", ret_valid, 1'b0);
      rsp(0, 65'h1_DEAD_BEEF, 1'b0);
      tick(); clr();
      check("rd_valid", ret_valid, 1'b1);
      check("rd_chan", ret_chan, 1'b0);
      check("rd_rdata", ret_cmd.rdata, 65'h1_DEAD_BEEF);
      check("rd_flag", ret_cmd.flag, 8'h00);
      check("rd_addr", ret_cmd.addr32, 30'h2000_0000);
      check("rd_cnt", retired_cnt, 32'd3);
      tick();
      check("rd_idle", ret_valid, 1'b0);

      both_chan(1'b1, "rr_b");

      // Cap write at byte 8300_0004: misaligned, outside DRAM, in TsMap, partial be.
      acc(0, 1'b1, 4'h3, 1'b1, 30'h20C0_0001, 65'h1_0000_00AB);
      tick(); clr(); tick();
      rsp(0, 65'h1_FFFF_FFFF, 1'b1);
      tick(); clr();
      check("cap_valid", ret_valid, 1'b1);
      check("cap_flag", ret_cmd.flag, 8'h17);
      check("cap_rdata", ret_cmd.rdata, 65'h0);
      check("cap_wdata", ret_cmd.wdata, 65'h1_0000_00AB);
      check("cap_err", ret_cmd.err, 1'b1);
      check("cap_we", ret_cmd.we, 1'b1);

      // Five accepts on ch1 into a 4-deep queue: fifth is dropped.
      for (int i = 0; i < 5; i++) begin
         acc(1, 1'b0, 4'hF, 1'b0, 30'h2000_0100 + 30'(i), '0);
         tick(); clr();
         if (i == 3) check("ovf_pre", overflow, 2'b00);
      end
      check("ovf_set", overflow, 2'b10);
      check("ovf_outst", outstanding, 4'd4);
      for (int i = 0; i < 4; i++) begin
         rsp(1, 65'(i), 1'b0);
         tick(); clr();
         check("ovf_ret_v", ret_valid, 1'b1);
         check("ovf_ret_ch", ret_chan, 1'b1);
         check("ovf_ret_addr", ret_cmd.addr32, 30'h2000_0100 + 30'(i));
      end
      tick();
      check("ovf_drain", outstanding, 4'd0);
      check("ovf_sticky", overflow, 2'b10);
      check("ovf_cnt", retired_cnt, 32'd10);

      // Full ch0 queue: accept and retire in the same cycle.
      for (int i = 0; i < 4; i++) begin
         acc(0, 1'b0, 4'hF, 1'b0, 30'h2000_0200 + 30'(i), '0);
         tick(); clr();
      end
      check("full_outst", outstanding, 4'd4);
      acc(0, 1'b0, 4'hF, 1'b0, 30'h2000_0204, '0);
      rsp(0, 65'h5, 1'b0);
      tick(); clr();
      check("full_outst_same", outstanding, 4'd4);
      check("full_no_ovf", overflow, 2'b10);
      check("full_ret_addr", ret_cmd.addr32, 30'h2000_0200);
      for (int i = 1; i < 5; i++) begin
         rsp(0, 65'h6, 1'b0);
         tick(); clr();
         check("full_drain_addr", ret_cmd.addr32, 30'h2000_0200 + 30'(i));
      end
      check("full_cnt", retired_cnt, 32'd15);
      check("full_empty", outstanding, 4'd0);

      // Spurious responses: idle channel, then a response to a same-cycle push.
      rsp(0, 65'h7, 1'b0);
      tick(); clr();
      check("spur_idle", spurious, 2'b01);
      acc(1, 1'b0, 4'hF, 1'b0, 30'h2000_0300, '0);
      rsp(1, 65'h8, 1'b0);
      tick(); clr();
      check("spur_same", spurious, 2'b11);
      check("spur_outst", outstanding, 4'd1);
      acc(1, 1'b0, 4'hF, 1'b0, 30'h2000_0301, '0);
      tick();
      acc(1, 1'b0, 4'hF, 1'b0, 30'h2000_0302, '0);
      tick(); clr();
      check("pre_rst_outst", outstanding, 4'd3);

      // Asynchronous reset mid-transaction.
      #2 rst_n = 1'b0;
      #1;
      check("arst_outst", outstanding, 4'd0);
      check("arst_cnt", retired_cnt, 32'd0);
      check("arst_ovf", overflow, 2'b00);
      check("arst_spur", spurious, 2'b00);
      check("arst_valid", ret_valid, 1'b0);
      check("arst_cmd", ret_cmd, '0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_outst", outstanding, 4'd0);
      rsp(1, 65'h9, 1'b0);
      tick(); clr();
      check("post_rst_spur", spurious, 2'b10);
      check("post_rst_valid", ret_valid, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
